// File: rtl/pe_accumulator.sv
// Signed accumulate stage of a TPU processing element: framed product beats in, one 34-bit sum out.
// Optional clamp-on-overflow behaviour is enabled with `define SATURATE_EN (default: wrap modulo 2^ACC_W).
module pe_accumulator #(
    parameter int unsigned IN_W  = 17,
    parameter int unsigned ACC_W = 34,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [IN_W-1:0]  in_data,
    input  logic             in_first,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_data,
    output logic [CNT_W-1:0] out_count,
    output logic             out_ovf
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
`ifdef SATURATE_EN
    localparam logic [ACC_W-1:0] SAT_POS = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] SAT_NEG = {1'b1, {(ACC_W-1){1'b0}}};
`endif

    state_e             state_q, state_d;
    logic [ACC_W-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               ovf_q, ovf_d;
    logic               in_ready_q, out_valid_q;

    logic               accept;
    logic [ACC_W-1:0]   ext_data;
    logic [ACC_W-1:0]   sum;
    logic               add_ovf;

    assign accept   = in_valid & in_ready_q;
    assign ext_data = ACC_W'($signed(in_data));
    assign sum      = acc_q + ext_data;
    // Signed overflow: operands agree in sign, result does not.
    assign add_ovf  = (acc_q[ACC_W-1] == ext_data[ACC_W-1]) && (sum[ACC_W-1] != acc_q[ACC_W-1]);

    // Next-state and datapath update.
    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        unique case (state_q)
            IDLE, ACC: begin
                if (accept) begin
                    if ((state_q == IDLE) || in_first) begin
                        acc_d   = ext_data;
                        count_d = CNT_W'(1);
                        ovf_d   = 1'b0;
                    end else begin
`ifdef SATURATE_EN
                        if (add_ovf) begin
                            acc_d = acc_q[ACC_W-1] ? SAT_NEG : SAT_POS;
                        end else begin
                            acc_d = sum;
                        end
`else
                        acc_d = sum;
`endif
                        count_d = (count_q == CNT_MAX) ? count_q : count_q + CNT_W'(1);
                        ovf_d   = ovf_q | add_ovf;
                    end
                    state_d = in_last ? DONE : ACC;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            count_q     <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            count_q     <= count_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= (state_d != DONE);
            out_valid_q <= (state_d == DONE);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign out_data  = acc_q;
    assign out_count = count_q;
    assign out_ovf   = ovf_q;

endmodule

// File: tb/tb_pe_accumulator.sv
// Directed bench for pe_accumulator: per-cycle vector table plus hand sequences for
// forced overflow, reset mid-sum / in DONE, and counter saturation.
module tb_pe_accumulator;

    localparam int unsigned IN_W  = 17;
    localparam int unsigned ACC_W = 34;
    localparam int unsigned CNT_W = 8;

    logic             clk;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_data;
    logic             in_first;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [ACC_W-1:0] out_data;
    logic [CNT_W-1:0] out_count;
    logic             out_ovf;

    int checks = 0;
    int errors = 0;

    pe_accumulator #(.IN_W(IN_W), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_first  (in_first),
        .in_last   (in_last),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_ovf   (out_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic             valid;
        logic [IN_W-1:0]  data;
        logic             first;
        logic             last;
        logic             oready;
        logic             exp_ir;
        logic             exp_ov;
        logic [ACC_W-1:0] exp_data;
        logic [CNT_W-1:0] exp_cnt;
        logic             exp_ovf;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic add_vec(input logic v, input int d, input logic f, input logic l, input logic r,
                           input logic eir, input logic eov, input longint ed, input int ec,
                           input logic eo);
        vec_t x;
        x.valid    = v;
        x.data     = IN_W'(d);
        x.first    = f;
        x.last     = l;
        x.oready   = r;
        x.exp_ir   = eir;
        x.exp_ov   = eov;
        x.exp_data = ACC_W'(ed);
        x.exp_cnt  = CNT_W'(ec);
        x.exp_ovf  = eo;
        vecs.push_back(x);
    endtask

    task automatic check_outs(input string tag, input logic eir, input logic eov,
                              input logic [ACC_W-1:0] ed, input logic [CNT_W-1:0] ec,
                              input logic eo);
        chk({tag, "_in_ready"},  64'(in_ready),  64'(eir));
        chk({tag, "_out_valid"}, 64'(out_valid), 64'(eov));
        chk({tag, "_out_data"},  64'(out_data),  64'(ed));
        chk({tag, "_out_count"}, 64'(out_count), 64'(ec));
        chk({tag, "_out_ovf"},   64'(out_ovf),   64'(eo));
    endtask

    // Drive one beat at the falling edge, let one rising edge happen.
    task automatic beat(input logic v, input int d, input logic f, input logic l, input logic r);
        in_valid  = v;
        in_data   = IN_W'(d);
        in_first  = f;
        in_last   = l;
        out_ready = r;
        @(posedge clk);
        #1;
    endtask

    logic [ACC_W-1:0] exp_wrap;

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_first  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;

        // valid data first last ordy | in_ready out_valid data count ovf
        // Sum 5 - 3 + 10; result one edge after the last beat
        add_vec(1, 5,  1, 0, 0,   1, 0, 5,  1, 0);
        add_vec(1, -3, 0, 0, 0,   1, 0, 2,  2, 0);
        add_vec(1, 10, 0, 1, 0,   0, 1, 12, 3, 0);
        add_vec(0, 0,  0, 0, 1,   1, 0, 12, 3, 0);
        // Single-beat sum of the most negative product
        add_vec(1, 32'sh10000, 1, 1, 1, 0, 1, -65536, 1, 0);
        // Back-pressure: next beat held while out_ready stays low
        for (int i = 0; i < 5; i++) add_vec(1, 8, 1, 0, 0, 0, 1, -65536, 1, 0);
        add_vec(1, 8,  1, 0, 1,   1, 0, -65536, 1, 0);
        add_vec(1, 8,  1, 0, 0,   1, 0, 8,  1, 0);
        add_vec(1, 2,  0, 1, 0,   0, 1, 10, 2, 0);
        add_vec(0, 0,  0, 0, 1,   1, 0, 10, 2, 0);
        // Restart mid-sum discards 7+9
        add_vec(1, 7,  1, 0, 0,   1, 0, 7,  1, 0);
        add_vec(1, 9,  0, 0, 0,   1, 0, 16, 2, 0);
        add_vec(1, 4,  1, 0, 1,   1, 0, 4,  1, 0);
        add_vec(1, 1,  0, 1, 0,   0, 1, 5,  2, 0);
        add_vec(0, 0,  0, 0, 1,   1, 0, 5,  2, 0);
        // First beat from IDLE loads even with in_first=0; one-term sum of -1
        add_vec(1, -1, 0, 1, 0,   0, 1, -1, 1, 0);
        add_vec(0, 0,  0, 0, 1,   1, 0, -1, 1, 0);

        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_data",  64'(out_data),  64'd0);
        chk("rst_out_count", 64'(out_count), 64'd0);
        chk("rst_out_ovf",   64'(out_ovf),   64'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd1);

        foreach (vecs[i]) begin
            beat(vecs[i].valid, int'($signed(vecs[i].data)), vecs[i].first, vecs[i].last,
                 vecs[i].oready);
            check_outs($sformatf("v%0d", i), vecs[i].exp_ir, vecs[i].exp_ov, vecs[i].exp_data,
                       vecs[i].exp_cnt, vecs[i].exp_ovf);
            @(negedge clk);
        end

        // Overflow: start a sum, preload acc to 2^33-2, add +3
        beat(1, 0, 1, 0, 0);
        @(negedge clk);
        in_valid = 1'b0;
        force dut.acc_q = 34'h1_FFFF_FFFE;
        #1;
        release dut.acc_q;
`ifdef SATURATE_EN
        exp_wrap = 34'h1_FFFF_FFFF;
`else
        exp_wrap = 34'h2_0000_0001;
`endif
        beat(1, 3, 0, 1, 0);
        check_outs("ovf", 1'b0, 1'b1, exp_wrap, CNT_W'(2), 1'b1);
        @(negedge clk);

        // Reset while DONE: pending result vanishes at once
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("rst_done_out_valid", 64'(out_valid), 64'd0);
        chk("rst_done_out_ovf",   64'(out_ovf),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset mid-sum
        beat(1, 5, 1, 0, 0);
        @(negedge clk);
        beat(1, 6, 0, 0, 0);
        check_outs("mid", 1'b1, 1'b0, 34'd11, CNT_W'(2), 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        chk("rst_mid_out_valid", 64'(out_valid), 64'd0);
        chk("rst_mid_out_count", 64'(out_count), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        beat(1, 9, 0, 1, 0);
        check_outs("clean", 1'b0, 1'b1, 34'd9, CNT_W'(1), 1'b0);
        @(negedge clk);
        beat(0, 0, 0, 0, 1);
        @(negedge clk);

        // 300 beats of +1: count saturates, sum does not
        for (int i = 0; i < 300; i++) begin
            beat(1, 1, (i == 0), (i == 299), 0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check_outs("sat", 1'b0, 1'b1, 34'd300, CNT_W'(255), 1'b0);
        beat(0, 0, 0, 0, 1);
        chk("sat_release_in_ready",  64'(in_ready),  64'd1);
        chk("sat_release_out_valid", 64'(out_valid), 64'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
